// File: rtl/regfile_wb.sv
// Write-back unit: owns the register file write port, arbitrating between the
// MEM/WB result and an in-order FIFO of multiply/divide results.
module regfile_wb #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_regwrite,
    input  logic [4:0]  mem_reg,
    input  logic        mem_memtoreg,
    input  logic [31:0] mem_alu,
    input  logic [31:0] mem_rdata,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_reg,
    input  logic [31:0] md_data,
    output logic        wb_stall,
    output logic [31:0] md_pend_mask,
    output logic        RegWrite,
    output logic [4:0]  Wreg,
    output logic [31:0] Wdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]       fifo_reg  [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [DEPTH-1:0] slot_vld;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    logic mem_req;
    logic full;
    logic pop;
    logic push;
    logic store;

    assign mem_req  = mem_regwrite && (mem_reg != 5'd0);
    assign full     = (count == CW'(DEPTH));
    assign pop      = !mem_req && (count != '0);
    // A full FIFO still accepts a result in the cycle its head drains.
    assign md_ready = rst && (!full || pop);
    assign push     = md_valid && md_ready;
    assign store    = push && (md_reg != 5'd0);
    assign wb_stall = full;

    always_ff @(posedge clk) begin
        if (store) begin
            fifo_reg[wr_ptr]  <= md_reg;
            fifo_data[wr_ptr] <= md_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            slot_vld <= '0;
        end else begin
            if (pop) begin
                rd_ptr           <= rd_ptr + AW'(1);
                slot_vld[rd_ptr] <= 1'b0;
            end
            // Set after clear so a slot recycled in the same cycle stays valid.
            if (store) begin
                wr_ptr           <= wr_ptr + AW'(1);
                slot_vld[wr_ptr] <= 1'b1;
            end
            count <= count + CW'(store) - CW'(pop);
        end
    end

    always_comb begin
        md_pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_vld[i]) begin
                md_pend_mask[fifo_reg[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWrite <= 1'b0;
            Wreg     <= '0;
            Wdata    <= '0;
        end else if (mem_req) begin
            RegWrite <= 1'b1;
            Wreg     <= mem_reg;
            Wdata    <= mem_memtoreg ? mem_rdata : mem_alu;
        end else if (pop) begin
            RegWrite <= 1'b1;
            Wreg     <= fifo_reg[rd_ptr];
            Wdata    <= fifo_data[rd_ptr];
        end else begin
            RegWrite <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: directed vector table, hand-written reset sequences,
// and randomized traffic against a queue-based reference model.
module tb_regfile_wb;
    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        mem_regwrite;
    logic [4:0]  mem_reg;
    logic        mem_memtoreg;
    logic [31:0] mem_alu;
    logic [31:0] mem_rdata;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_reg;
    logic [31:0] md_data;
    logic        wb_stall;
    logic [31:0] md_pend_mask;
    logic        RegWrite;
    logic [4:0]  Wreg;
    logic [31:0] Wdata;

    regfile_wb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_regwrite(mem_regwrite), .mem_reg(mem_reg), .mem_memtoreg(mem_memtoreg),
        .mem_alu(mem_alu), .mem_rdata(mem_rdata),
        .md_valid(md_valid), .md_ready(md_ready), .md_reg(md_reg), .md_data(md_data),
        .wb_stall(wb_stall), .md_pend_mask(md_pend_mask),
        .RegWrite(RegWrite), .Wreg(Wreg), .Wdata(Wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        mw;
        logic [4:0]  mr;
        logic        mtr;
        logic [31:0] alu;
        logic [31:0] rd;
        logic        mv;
        logic [4:0]  mdr;
        logic [31:0] mdd;
        logic        rdy;
        logic        st;
        logic [31:0] mask;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
    } vec_t;

    vec_t tbl [32];
    int   nv = 0;
    int   vectors = 0;
    int   misc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic mw, input logic [4:0] mr, input logic mtr,
                       input logic [31:0] alu, input logic [31:0] rd,
                       input logic mv, input logic [4:0] mdr, input logic [31:0] mdd,
                       input logic rdy, input logic st, input logic [31:0] mask,
                       input logic we, input logic [4:0] wreg, input logic [31:0] wdata);
        tbl[nv] = '{mw, mr, mtr, alu, rd, mv, mdr, mdd, rdy, st, mask, we, wreg, wdata};
        nv++;
    endtask

    // Reference model state
    logic [4:0]  q_reg  [$];
    logic [31:0] q_data [$];
    logic        exp_we;
    logic [4:0]  exp_wreg;
    logic [31:0] exp_wdata;

    initial begin
        logic        req;
        logic        pop_m;
        logic        rdy_m;
        logic [31:0] mask_m;

        // MEM path, r0 drop, priority/fill, push+pop at full, r0 push, duplicates
        add(1'b1, 5'd8,  1'b1, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0,     1'b1, 1'b0, 32'h0,     1'b1, 5'd8,  32'hDEAD_BEEF);
        add(1'b1, 5'd0,  1'b0, 32'h0000_AAAA, 32'h0,         1'b0, 5'd0,  32'h0,     1'b1, 1'b0, 32'h0,     1'b0, 5'd8,  32'hDEAD_BEEF);
        add(1'b1, 5'd9,  1'b0, 32'h0000_0099, 32'h0000_FFFF, 1'b1, 5'd3,  32'h333,   1'b1, 1'b0, 32'h0,     1'b1, 5'd9,  32'h99);
        add(1'b1, 5'd10, 1'b0, 32'h0000_00A0, 32'h0,         1'b1, 5'd4,  32'h444,   1'b1, 1'b0, 32'h8,     1'b1, 5'd10, 32'hA0);
        add(1'b1, 5'd11, 1'b0, 32'h0000_00B0, 32'h0,         1'b1, 5'd12, 32'hCCC,   1'b0, 1'b1, 32'h18,    1'b1, 5'd11, 32'hB0);
        add(1'b0, 5'd0,  1'b0, 32'h0,         32'h0,         1'b0, 5'd0,  32'h0,     1'b1, 1'b1, 32'h18,    1'b1, 5'd3,  32'h333);
        add(1'b0, 5'd0,  1'b0, 32'h0,         32'h0,         1'b0, 5'd0,  32'h0,     1'b1, 1'b0, 32'h10,    1'b1, 5'd4,  32'h444);
        add(1'b0, 5'd0,  1'b0, 32'h0,         32'h0,         1'b0, 5'd0,  32'h0,     1'b1, 1'b0, 32'h0,     1'b0, 5'd4,  32'h444);
        add(1'b1, 5'd1,  1'b0, 32'h1,         32'h0,         1'b1, 5'd3,  32'h3333,  1'b1, 1'b0, 32'h0,     1'b1, 5'd1,  32'h1);
        add(1'b1, 5'd2,  1'b0, 32'h2,         32'h0,         1'b1, 5'd4,  32'h4444,  1'b1, 1'b0, 32'h8,     1'b1, 5'd2,  32'h2);
        add(1'b0, 5'd0,  1'b0, 32'h0,         32'h0,         1'b1, 5'd9,  32'h9999,  1'b1, 1'b1, 32'h18,    1'b1, 5'd3,  32'h3333);
        add(1'b0, 5'd0,  1'b0, 32'h0,         32'h0,         1'b0, 5'd0,  32'h0,     1'b1, 1'b1, 32'h210,   1'b1, 5'd4,  32'h4444);
        add(1'b0, 5'd0,  1'b0, 32'h0,         32'h0,         1'b1, 5'd0,  32'hDEAD,  1'b1, 1'b0, 32'h200,   1'b1, 5'd9,  32'h9999);
        add(1'b0, 5'd0,  1'b0, 32'h0,         32'h0,         1'b0, 5'd0,  32'h0,     1'b1, 1'b0, 32'h0,     1'b0, 5'd9,  32'h9999);
        add(1'b1, 5'd5,  1'b0, 32'h55,        32'h0,         1'b1, 5'd7,  32'h71,    1'b1, 1'b0, 32'h0,     1'b1, 5'd5,  32'h55);
        add(1'b1, 5'd6,  1'b0, 32'h66,        32'h0,         1'b1, 5'd7,  32'h72,    1'b1, 1'b0, 32'h80,    1'b1, 5'd6,  32'h66);
        add(1'b0, 5'd0,  1'b0, 32'h0,         32'h0,         1'b0, 5'd0,  32'h0,     1'b1, 1'b1, 32'h80,    1'b1, 5'd7,  32'h71);
        add(1'b0, 5'd0,  1'b0, 32'h0,         32'h0,         1'b0, 5'd0,  32'h0,     1'b1, 1'b0, 32'h80,    1'b1, 5'd7,  32'h72);
        add(1'b0, 5'd0,  1'b0, 32'h0,         32'h0,         1'b0, 5'd0,  32'h0,     1'b1, 1'b0, 32'h0,     1'b0, 5'd7,  32'h72);

        // Reset values, then first MD push through an empty FIFO
        rst = 1'b0;
        mem_regwrite = 1'b0; mem_reg = 5'd0; mem_memtoreg = 1'b0;
        mem_alu = 32'h0; mem_rdata = 32'h0;
        md_valid = 1'b1; md_reg = 5'd5; md_data = 32'h1234;
        #2;
        chk("rst_regwrite", 32'(RegWrite), 32'h0);
        chk("rst_md_ready", 32'(md_ready), 32'h0);
        chk("rst_mask", md_pend_mask, 32'h0);
        chk("rst_stall", 32'(wb_stall), 32'h0);
        chk("rst_wreg", 32'(Wreg), 32'h0);
        chk("rst_wdata", Wdata, 32'h0);
        @(posedge clk); #1;
        chk("rst_hold_mask", md_pend_mask, 32'h0);
        chk("rst_hold_regwrite", 32'(RegWrite), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_md_ready", 32'(md_ready), 32'h1);
        @(posedge clk); #1;
        md_valid = 1'b0;
        chk("push5_mask", md_pend_mask, 32'h20);
        chk("push5_regwrite", 32'(RegWrite), 32'h0);
        @(posedge clk); #1;
        chk("pop5_regwrite", 32'(RegWrite), 32'h1);
        chk("pop5_wreg", 32'(Wreg), 32'd5);
        chk("pop5_wdata", Wdata, 32'h1234);
        chk("pop5_mask", md_pend_mask, 32'h0);

        for (int i = 0; i < nv; i++) begin
            mem_regwrite = tbl[i].mw;  mem_reg = tbl[i].mr; mem_memtoreg = tbl[i].mtr;
            mem_alu = tbl[i].alu;      mem_rdata = tbl[i].rd;
            md_valid = tbl[i].mv;      md_reg = tbl[i].mdr; md_data = tbl[i].mdd;
            #1;
            chk($sformatf("v%0d_md_ready", i), 32'(md_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_wb_stall", i), 32'(wb_stall), 32'(tbl[i].st));
            chk($sformatf("v%0d_mask", i), md_pend_mask, tbl[i].mask);
            @(posedge clk); #1;
            chk($sformatf("v%0d_regwrite", i), 32'(RegWrite), 32'(tbl[i].we));
            chk($sformatf("v%0d_wreg", i), 32'(Wreg), 32'(tbl[i].wreg));
            chk($sformatf("v%0d_wdata", i), Wdata, tbl[i].wdata);
        end

        // Asynchronous reset while two results are queued
        mem_regwrite = 1'b1; mem_reg = 5'd13; mem_alu = 32'hD; mem_memtoreg = 1'b0;
        md_valid = 1'b1; md_reg = 5'd20; md_data = 32'h2020;
        @(posedge clk); #1;
        mem_reg = 5'd14; mem_alu = 32'hE;
        md_reg = 5'd21; md_data = 32'h2121;
        @(posedge clk); #1;
        mem_regwrite = 1'b0; md_valid = 1'b0;
        #1;
        chk("ar_full_stall", 32'(wb_stall), 32'h1);
        chk("ar_full_mask", md_pend_mask, 32'h0030_0000);
        @(posedge clk); #1;
        chk("ar_pop_regwrite", 32'(RegWrite), 32'h1);
        chk("ar_pop_wreg", 32'(Wreg), 32'd20);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_regwrite", 32'(RegWrite), 32'h0);
        chk("ar_mask", md_pend_mask, 32'h0);
        chk("ar_stall", 32'(wb_stall), 32'h0);
        chk("ar_md_ready", 32'(md_ready), 32'h0);
        chk("ar_wreg", 32'(Wreg), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("ar_after1_regwrite", 32'(RegWrite), 32'h0);
        chk("ar_after1_wreg", 32'(Wreg), 32'h0);
        @(posedge clk); #1;
        chk("ar_after2_regwrite", 32'(RegWrite), 32'h0);
        chk("ar_after2_mask", md_pend_mask, 32'h0);

        // Randomized traffic against the queue model
        exp_we = 1'b0; exp_wreg = 5'd0; exp_wdata = 32'h0;
        for (int c = 0; c < 400; c++) begin
            mem_regwrite = ($urandom_range(0, 99) < 50);
            mem_reg      = 5'($urandom_range(0, 31));
            mem_memtoreg = 1'($urandom_range(0, 1));
            mem_alu      = $urandom;
            mem_rdata    = $urandom;
            md_valid     = ($urandom_range(0, 99) < 45);
            md_reg       = 5'($urandom_range(0, 15));
            md_data      = $urandom;
            #1;
            req   = mem_regwrite && (mem_reg != 5'd0);
            pop_m = !req && (q_reg.size() != 0);
            rdy_m = (q_reg.size() < DEPTH) || pop_m;
            mask_m = 32'h0;
            foreach (q_reg[k]) mask_m = mask_m | (32'h1 << q_reg[k]);
            chk("rnd_md_ready", 32'(md_ready), 32'(rdy_m));
            chk("rnd_wb_stall", 32'(wb_stall), 32'(q_reg.size() == DEPTH));
            chk("rnd_mask", md_pend_mask, mask_m);
            if (req) begin
                exp_we = 1'b1; exp_wreg = mem_reg;
                exp_wdata = mem_memtoreg ? mem_rdata : mem_alu;
            end else if (pop_m) begin
                exp_we = 1'b1;
                exp_wreg = q_reg.pop_front();
                exp_wdata = q_data.pop_front();
            end else begin
                exp_we = 1'b0;
            end
            if (md_valid && rdy_m && (md_reg != 5'd0)) begin
                q_reg.push_back(md_reg);
                q_data.push_back(md_data);
            end
            @(posedge clk); #1;
            chk("rnd_regwrite", 32'(RegWrite), 32'(exp_we));
            chk("rnd_wreg", 32'(Wreg), 32'(exp_wreg));
            chk("rnd_wdata", Wdata, exp_wdata);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end
endmodule
